// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int DEFAULT_ADDR_W = 8;

  localparam logic [31:0] TERMINATOR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte handshake plus big-endian shift register; flags the 4th byte of each word.
// Handshake: a byte transfers on a rising edge where valid_i && ready_i.
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        ready_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic [23:0] shift_q;
  logic [23:0] shift_d;
  logic        accept;

  assign accept = byte_valid_i && ready_i;

  // The assembled word includes the byte being accepted this cycle.
  assign word_o       = {shift_q, byte_data_i};
  assign word_valid_o = accept && (idx_q == 2'd3);

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d   = 2'd0;
      shift_d = '0;
    end else if (accept) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], byte_data_i};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words, writes instruction memory, releases the core.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit checksum word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              core_run,
  output logic              load_done,
  output logic              load_error,
  output state_t            dbg_state
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t          state_q;
  logic            byte_ready_q;
  logic            imem_we_q;
  logic [31:0]     imem_addr_q;
  logic [31:0]     imem_wdata_q;
  logic [ADDR_W:0] word_count_q;
  logic [ADDR_W:0] word_count_d;
  logic            core_run_q;
  logic            load_done_q;
  logic            load_error_q;
  logic            start_load;
  logic            word_valid;
  logic [31:0]     word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]     sum_q;
`endif

  assign start_load   = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign word_count_d = word_count_q + (ADDR_W+1)'(1);

  byte_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (start_load),
    .ready_i      (byte_ready_q),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      word_count_q <= '0;
      core_run_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state_q      <= ST_LOAD;
            byte_ready_q <= 1'b1;
            word_count_q <= '0;
            load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
          end
        end

        ST_LOAD: begin
          if (word_valid) begin
            // The terminator is written too so the core halts on it once released.
            imem_we_q    <= 1'b1;
            imem_addr_q  <= 32'({word_count_q, 2'b00});
            imem_wdata_q <= word;
            word_count_q <= word_count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_q + word;
`endif
            if (word == TERMINATOR) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q      <= ST_CHECK;
`else
              state_q      <= ST_RUN;
              byte_ready_q <= 1'b0;
              core_run_q   <= 1'b1;
              load_done_q  <= 1'b1;
`endif
            end else if (word_count_d == MAX_WORDS) begin
              state_q      <= ST_ERROR;
              byte_ready_q <= 1'b0;
              load_error_q <= 1'b1;
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          // Checksum word is compared only; it never reaches memory.
          if (word_valid) begin
            byte_ready_q <= 1'b0;
            if (word == sum_q) begin
              state_q     <= ST_RUN;
              core_run_q  <= 1'b1;
              load_done_q <= 1'b1;
            end else begin
              state_q      <= ST_ERROR;
              load_error_q <= 1'b1;
            end
          end
        end
`endif

        ST_RUN: begin
        end

        default: begin
          state_q      <= ST_IDLE;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
  assign core_run   = core_run_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven word vectors plus corner-case sequences.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        byte_ready, imem_we, core_run, load_done, load_error;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  word_count;
  state_t      dbg_state;

  logic        s_byte_ready, s_imem_we, s_core_run, s_load_done, s_load_error;
  logic [31:0] s_imem_addr, s_imem_wdata;
  logic [2:0]  s_word_count;
  state_t      s_dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic CSUM = 1'b1;
`else
  localparam logic CSUM = 1'b0;
`endif

  imem_loader #(.ADDR_W(8)) u_dut (
    .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
    .core_run(core_run), .load_done(load_done), .load_error(load_error),
    .dbg_state(dbg_state)
  );

  imem_loader #(.ADDR_W(2)) u_small (
    .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(s_byte_ready), .imem_we(s_imem_we),
    .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .word_count(s_word_count),
    .core_run(s_core_run), .load_done(s_load_done), .load_error(s_load_error),
    .dbg_state(s_dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  always @(negedge clock) if (imem_we) we_cnt = we_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  // scoreboard helper
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start(input logic with_byte);
    start = 1'b1; byte_valid = with_byte; byte_data = 8'hEE;
    @(posedge clock);
    #1 start = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    byte_valid = 1'b1; byte_data = b;
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [15:0] gaps);
    for (int k = 0; k < 4; k++)
      send_byte(w[31-8*k -: 8], int'(gaps[4*k +: 4]));
  endtask

  typedef struct {
    logic [31:0] bytes;
    logic [15:0] gaps;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [8:0]  exp_count;
    logic        exp_run;
    logic        exp_ready;
    int          exp_we_total;
  } vec_t;

  vec_t vecs[4];
  logic [31:0] small_words[4];
  int we_before;

  initial begin
    vecs[0] = '{32'h2008_0005, 16'h0000, 32'd0, 32'h2008_0005, 9'd1, 1'b0, 1'b1, 1};
    vecs[1] = '{32'hFFFF_FFFF, 16'h0000, 32'd4, 32'hFFFF_FFFF, 9'd2, !CSUM, CSUM, 2};
    vecs[2] = '{32'h2008_0005, 16'h2031, 32'd0, 32'h2008_0005, 9'd1, 1'b0, 1'b1, 3};
    vecs[3] = '{32'hFFFF_FFFF, 16'h1302, 32'd4, 32'hFFFF_FFFF, 9'd2, !CSUM, CSUM, 4};
    small_words[0] = 32'h1111_1111;
    small_words[1] = 32'h2222_2222;
    small_words[2] = 32'h3333_3333;
    small_words[3] = 32'h4444_4444;

    // reset state after idle cycles
    do_reset();
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_core_run", core_run, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // start together with a byte: start wins, byte is not taken
    pulse_start(1'b1);
    @(negedge clock);
    check("start_byte_ready", byte_ready, 1);
    check("start_state", 32'(dbg_state), 32'(ST_LOAD));

    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        do_reset();
        pulse_start(1'b0);
      end
      send_word(vecs[i].bytes, vecs[i].gaps);
      @(negedge clock);
      check($sformatf("v%0d_we", i), imem_we, 1);
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_data", i), imem_wdata, vecs[i].exp_data);
      check($sformatf("v%0d_count", i), 32'(word_count), 32'(vecs[i].exp_count));
      check($sformatf("v%0d_core_run", i), core_run, vecs[i].exp_run);
      check($sformatf("v%0d_load_done", i), load_done, vecs[i].exp_run);
      check($sformatf("v%0d_byte_ready", i), byte_ready, vecs[i].exp_ready);
      @(negedge clock);
      check($sformatf("v%0d_we_pulse_end", i), imem_we, 0);
      check($sformatf("v%0d_we_total", i), we_cnt, vecs[i].exp_we_total);
    end

    // overflow on a 4-word memory, then restart from address 0
    do_reset();
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      send_word(small_words[i], 16'h0000);
      @(negedge clock);
      check($sformatf("ovf%0d_we", i), s_imem_we, 1);
      check($sformatf("ovf%0d_addr", i), s_imem_addr, 32'(4 * i));
      check($sformatf("ovf%0d_data", i), s_imem_wdata, small_words[i]);
    end
    check("ovf_load_error", s_load_error, 1);
    check("ovf_byte_ready", s_byte_ready, 0);
    check("ovf_count", 32'(s_word_count), 4);
    check("ovf_state", 32'(s_dbg_state), 32'(ST_ERROR));
    pulse_start(1'b0);
    @(negedge clock);
    check("restart_error_clr", s_load_error, 0);
    check("restart_ready", s_byte_ready, 1);
    check("restart_count", 32'(s_word_count), 0);
    send_word(32'hAABB_CCDD, 16'h0000);
    @(negedge clock);
    check("restart_we", s_imem_we, 1);
    check("restart_addr", s_imem_addr, 0);
    check("restart_data", s_imem_wdata, 32'hAABB_CCDD);
    check("restart_count1", 32'(s_word_count), 1);

    // reset after two bytes drops the partial word
    do_reset();
    pulse_start(1'b0);
    we_before = we_cnt;
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_ready", byte_ready, 0);
    check("midrst_count", 32'(word_count), 0);
    check("midrst_no_we", we_cnt, we_before);
    pulse_start(1'b0);
    send_word(32'hC0DE_0001, 16'h0000);
    @(negedge clock);
    check("midrst_we", imem_we, 1);
    check("midrst_addr", imem_addr, 0);
    check("midrst_data", imem_wdata, 32'hC0DE_0001);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // matching checksum: 1 + 2 + FFFFFFFF = 2 mod 2^32
    do_reset();
    pulse_start(1'b0);
    send_word(32'h0000_0001, 16'h0000);
    send_word(32'h0000_0002, 16'h0000);
    send_word(32'hFFFF_FFFF, 16'h0000);
    @(negedge clock);
    check("cs_check_state", 32'(dbg_state), 32'(ST_CHECK));
    check("cs_check_run", core_run, 0);
    send_word(32'h0000_0002, 16'h0100);
    @(negedge clock);
    check("cs_ok_run", core_run, 1);
    check("cs_ok_done", load_done, 1);
    check("cs_ok_no_we", imem_we, 0);
    check("cs_ok_count", 32'(word_count), 3);
    check("cs_ok_state", 32'(dbg_state), 32'(ST_RUN));

    do_reset();
    pulse_start(1'b0);
    send_word(32'h0000_0001, 16'h0000);
    send_word(32'h0000_0002, 16'h0000);
    send_word(32'hFFFF_FFFF, 16'h0000);
    send_word(32'h0000_0003, 16'h0000);
    @(negedge clock);
    check("cs_bad_error", load_error, 1);
    check("cs_bad_run", core_run, 0);
    check("cs_bad_state", 32'(dbg_state), 32'(ST_ERROR));
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the fetch stage. Accepts a byte stream over a valid/ready handshake, packs big-endian 32-bit instruction words, and writes them into instruction memory starting at byte address 0. When the all-ones halt word arrives, it releases the processor by asserting `core_run`, which gates the clock generator's halt input. Until then the core is held stopped.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; capacity `MAX_WORDS = 2**ADDR_W` words.

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a load; sampled in IDLE and ERROR.
- `byte_valid`  in  1  upstream byte present.
- `byte_data`  in  8  stream byte, MSB-first within each word.
- `byte_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address (word index × 4, bits [1:0] = 0).
- `imem_wdata`  out  32  packed instruction word.
- `word_count`  out  ADDR_W+1  words written so far, including the terminator.
- `core_run`  out  1  high = processor released; driven to the halt path inverted.
- `load_done`  out  1  load finished successfully.
- `load_error`  out  1  load failed.

## Operation
- States:
  - **IDLE**: `byte_ready`=0. `start` → LOAD.
  - **LOAD**: `byte_ready`=1.
  - **CHECK**: exists only with the macro.
  - **RUN**: `core_run`=`load_done`=1, `byte_ready`=0. Terminal until `reset`; `start` is ignored.
  - **ERROR**: `load_error`=1, `byte_ready`=0. `start` → LOAD.
- Entry to LOAD clears the byte index, the word register, `word_count`, the write pointer and the checksum accumulator.
- A byte is accepted on a clock edge where `byte_valid && byte_ready`.
- Packing: `word = {word[23:0], byte_data}`. A 2-bit byte index wraps 3→0 on the 4th byte.
- On the 4th byte, the word is written to address `word_count*4` and `word_count` increments.
  - If the word equals `32'hFFFF_FFFF` (TERMINATOR), it is still written, so the core halts on it. The FSM then goes to CHECK (macro defined) or RUN (macro undefined).
  - If, after the write, `word_count == MAX_WORDS` and the word is not TERMINATOR → ERROR.
- Byte stalls (`byte_valid` low) are allowed anywhere mid-word; the partial word is retained.
- Address arithmetic: `imem_addr = {word_count, 2'b00}` zero-extended to 32 bits. It never wraps, because the overflow check above fires first.
- Reset mid-load: the partial word is discarded and the FSM returns to IDLE. Already-written memory contents are not scrubbed.

## Timing
- Reset values:
  - `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `word_count`=0, `core_run`=0, `load_done`=0, `load_error`=0.
  - State = IDLE.
- `byte_ready` rises the cycle after the `start` edge.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered and valid for exactly the one cycle following the 4th-byte handshake edge. `word_count` updates on that same edge.
- Maximum throughput is one byte per cycle, so at most one `imem_we` every 4 cycles. No backpressure is generated in LOAD.
- Terminator word: `imem_we` pulses in the cycle after the 4th-byte handshake, while the FSM enters CHECK or RUN.
  - Without the macro, `core_run` and `load_done` are therefore high in that same cycle.
  - The memory write completes at the following edge, and fetch samples address 0 no earlier than the next falling edge.
- `start` and `byte_valid` asserted together in IDLE: `start` wins; the byte is not accepted because `byte_ready`=0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`
- Defined:
  - Every written word, terminator included, is summed mod 2^32.
  - After the terminator, CHECK accepts 4 more bytes (same packing) as the expected checksum. These bytes are not written to memory.
  - Match → RUN. Mismatch → ERROR.
- Undefined: no accumulator, no CHECK state; terminator → RUN directly.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum (IDLE, LOAD, CHECK, RUN, ERROR);
  - `TERMINATOR = 32'hFFFF_FFFF`;
  - default `ADDR_W`.
- Sub-module `byte_packer`: handshake, byte index and shift register. Outputs a one-cycle `word_valid` plus `word`. It is reused for the checksum word.
- Top level holds the FSM, counters, accumulator and write-port registers.

## Test plan
- Reset, then 8 idle cycles → all outputs 0, `byte_ready`=0.
- `start`, then bytes 20 08 00 05, FF FF FF FF with no gaps:
  - `imem_we` at addr 0 with `32'h2008_0005`;
  - then at addr 4 with TERMINATOR;
  - `word_count`=2, `core_run`=1 (macro off).
- Same stream with random `byte_valid` gaps, including mid-word → identical writes and data; `imem_we` pulses only after each 4th byte.
- `ADDR_W`=2, 4 non-terminator words → 4 writes to addrs 0/4/8/12, then ERROR. `start` again loads from addr 0.
- Macro on:
  - words 1, 2, TERMINATOR, then checksum `32'h0000_0002` → RUN (sum is 1+2+`FFFFFFFF` mod 2^32);
  - checksum `32'h0000_0003` → ERROR, `core_run`=0.
- `reset` asserted after 2 bytes of word 1 → IDLE next cycle, no `imem_we`. A new `start` repacks from byte 0.
